// File: rtl/sha256_round_ctrl_if.sv
// Block-input and digest-output handshake between the SHA-256 round controller and its
// producer/consumer. The controller side uses the slave modport.
interface sha256_round_ctrl_if;
  logic blk_valid;
  logic blk_first;
  logic blk_ready;
  logic digest_valid;
  logic digest_ack;

  modport master (
    output blk_valid,
    output blk_first,
    output digest_ack,
    input  blk_ready,
    input  digest_valid
  );

  modport slave (
    input  blk_valid,
    input  blk_first,
    input  digest_ack,
    output blk_ready,
    output digest_valid
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round controller: IDLE -> INIT -> ROUND x ROUNDS -> UPDATE -> DONE.
// Optional SHA256_CTRL_BLKCNT_EN adds a saturating 16-bit completed-digest counter (blk_cnt).
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned TW     = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  sha256_round_ctrl_if.slave   bus,
  output logic                 w_ld,
  output logic                 ld_init,
  output logic                 sel_iv,
  output logic                 hash_iv,
  output logic                 rnd_en,
  output logic [TW-1:0]        t,
  output logic                 hash_upd,
  output logic                 busy
`ifdef SHA256_CTRL_BLKCNT_EN
  ,
  output logic [15:0]          blk_cnt
`endif
);

  localparam logic [TW-1:0] TLast = TW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRound,
    StUpdate,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            first_q, first_d;
  logic [TW-1:0]   t_q, t_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      first_q <= 1'b0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    first_d          = first_q;
    t_d              = t_q;
    w_ld             = 1'b0;
    ld_init          = 1'b0;
    sel_iv           = 1'b0;
    hash_iv          = 1'b0;
    rnd_en           = 1'b0;
    hash_upd         = 1'b0;
    bus.blk_ready    = 1'b0;
    bus.digest_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.blk_ready = 1'b1;
        // w_ld is combinational from blk_valid, so it must be masked while reset is held
        if (bus.blk_valid && !RST) begin
          w_ld    = 1'b1;
          first_d = bus.blk_first;
          state_d = StInit;
        end
      end
      StInit: begin
        ld_init = 1'b1;
        sel_iv  = first_q;
        hash_iv = first_q;
        t_d     = '0;
        state_d = StRound;
      end
      StRound: begin
        rnd_en = 1'b1;
        // t parks on the last index rather than wrapping
        if (t_q == TLast) begin
          state_d = StUpdate;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      StUpdate: begin
        hash_upd = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        bus.digest_valid = 1'b1;
        if (bus.digest_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign t    = t_q;
  assign busy = (state_q != StIdle);

`ifdef SHA256_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blk_cnt_q <= '0;
    end else if (bus.digest_valid && bus.digest_ack && (blk_cnt_q != 16'hFFFF)) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`else
  // No completed-digest counter in this build.
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed table-driven bench for sha256_round_ctrl (ROUNDS=64, TW=6); exercises the
// SHA256_CTRL_BLKCNT_EN counter when that macro is defined.
module tb_sha256_round_ctrl;

  typedef struct packed {
    logic       w_ld;
    logic       ld_init;
    logic       sel_iv;
    logic       hash_iv;
    logic       rnd_en;
    logic [5:0] t;
    logic       hash_upd;
    logic       digest_valid;
    logic       blk_ready;
    logic       busy;
  } obs_t;

  typedef struct {
    int    blk;
    int    cyc;
    obs_t  exp;
    string name;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic       w_ld, ld_init, sel_iv, hash_iv, rnd_en, hash_upd, busy;
  logic [5:0] t;
`ifdef SHA256_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  sha256_round_ctrl_if bus ();

  sha256_round_ctrl #(
    .ROUNDS (64),
    .TW     (6)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .w_ld     (w_ld),
    .ld_init  (ld_init),
    .sel_iv   (sel_iv),
    .hash_iv  (hash_iv),
    .rnd_en   (rnd_en),
    .t        (t),
    .hash_upd (hash_upd),
    .busy     (busy)
`ifdef SHA256_CTRL_BLKCNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int   checks = 0;
  int   failures = 0;
  int   n_upd = 0;
  bit   chk_on = 1'b0;
  obs_t cap [4][68];
  vec_t vecs [$];

  function automatic obs_t mk(logic wl, logic li, logic si, logic hi, logic re, logic [5:0] tt,
                              logic hu, logic dv, logic rdy, logic bz);
    obs_t o;
    o = '{w_ld: wl, ld_init: li, sel_iv: si, hash_iv: hi, rnd_en: re, t: tt,
          hash_upd: hu, digest_valid: dv, blk_ready: rdy, busy: bz};
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(w_ld, ld_init, sel_iv, hash_iv, rnd_en, t, hash_upd, bus.digest_valid,
              bus.blk_ready, busy);
  endfunction

  function automatic void add(int blk, int cyc, obs_t e, string name);
    vec_t v;
    v.blk = blk; v.cyc = cyc; v.exp = e; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk_obs(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_bit(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One block from handshake (cycle 0) to the first DONE cycle (67). blk_valid is held high
  // and blk_first inverted after cycle 0 to show both are ignored outside IDLE; digest_ack is
  // pulsed while not in DONE.
  task automatic run_block(input int idx, input logic first, input logic ack_at_done);
    for (int c = 0; c < 68; c++) begin
      bus.blk_valid  = 1'b1;
      bus.blk_first  = (c == 0) ? first : ~first;
      bus.digest_ack = ((c >= 5) && (c <= 66)) || ((c == 67) && ack_at_done);
      @(negedge CLK);
      cap[idx][c] = sample();
      @(posedge CLK);
      #1;
    end
    bus.blk_valid  = 1'b0;
    bus.digest_ack = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (hash_upd) n_upd++;
    if (chk_on && !RST) begin
      logic [4:0] s;
      s = {w_ld, ld_init, rnd_en, hash_upd, hash_iv};
      checks++;
      if (!(($countones(s) <= 1) || (s == 5'b01001))) begin
        failures++;
        $display("FAIL strobe_excl got=%b exp=one-hot", s);
      end
    end
  end

  initial begin
    obs_t rst_exp;
    rst_exp = mk(0, 0, 0, 0, 0, 6'd0, 0, 0, 1, 0);

    // blk 1: fresh after reset (t=0 before INIT); blk 2: chained (t parked at 63)
    add(1, 0,  mk(1, 0, 0, 0, 0, 6'd0,  0, 0, 1, 0), "hs");
    add(1, 1,  mk(0, 1, 1, 1, 0, 6'd0,  0, 0, 0, 1), "init_iv");
    add(1, 2,  mk(0, 0, 0, 0, 1, 6'd0,  0, 0, 0, 1), "rnd_t0");
    add(1, 3,  mk(0, 0, 0, 0, 1, 6'd1,  0, 0, 0, 1), "rnd_t1");
    add(1, 32, mk(0, 0, 0, 0, 1, 6'd30, 0, 0, 0, 1), "rnd_t30");
    add(1, 65, mk(0, 0, 0, 0, 1, 6'd63, 0, 0, 0, 1), "rnd_t63");
    add(1, 66, mk(0, 0, 0, 0, 0, 6'd63, 1, 0, 0, 1), "update");
    add(1, 67, mk(0, 0, 0, 0, 0, 6'd63, 0, 1, 0, 1), "done");
    add(2, 0,  mk(1, 0, 0, 0, 0, 6'd63, 0, 0, 1, 0), "hs_chain");
    add(2, 1,  mk(0, 1, 0, 0, 0, 6'd63, 0, 0, 0, 1), "init_chain");
    add(2, 2,  mk(0, 0, 0, 0, 1, 6'd0,  0, 0, 0, 1), "rnd_t0_chain");
    add(2, 40, mk(0, 0, 0, 0, 1, 6'd38, 0, 0, 0, 1), "rnd_t38_chain");
    add(2, 65, mk(0, 0, 0, 0, 1, 6'd63, 0, 0, 0, 1), "rnd_t63_chain");
    add(2, 66, mk(0, 0, 0, 0, 0, 6'd63, 1, 0, 0, 1), "update_chain");
    add(2, 67, mk(0, 0, 0, 0, 0, 6'd63, 0, 1, 0, 1), "done_chain");

    // Reset held with a block offered: nothing may be accepted
    RST = 1'b1;
    bus.blk_valid  = 1'b1;
    bus.blk_first  = 1'b1;
    bus.digest_ack = 1'b1;
    #3;
    chk_obs("reset_state", sample(), rst_exp);
    repeat (2) @(posedge CLK);
    #1;
    chk_obs("reset_held", sample(), rst_exp);
    RST = 1'b0;
    bus.blk_valid  = 1'b0;
    bus.digest_ack = 1'b0;
    chk_on = 1'b1;
    @(posedge CLK);
    #1;

    run_block(0, 1'b1, 1'b0);

    // DONE hold for 10 cycles with blk_valid toggling and no ack
    for (int i = 0; i < 10; i++) begin
      bus.blk_valid = (i % 2 == 0);
      @(negedge CLK);
      chk_bit("hold_dv", bus.digest_valid, 1'b1);
      chk_bit("hold_ready", bus.blk_ready, 1'b0);
      chk_bit("hold_wld", w_ld, 1'b0);
      @(posedge CLK);
      #1;
    end
    bus.blk_valid  = 1'b0;
    bus.digest_ack = 1'b1;
    @(negedge CLK);
    chk_bit("ack_cycle_dv", bus.digest_valid, 1'b1);
    @(posedge CLK);
    #1;
    bus.digest_ack = 1'b0;
    @(negedge CLK);
    chk_bit("after_ack_ready", bus.blk_ready, 1'b1);
    chk_bit("after_ack_busy", busy, 1'b0);
    @(posedge CLK);
    #1;

    // Chained block, acked in the very cycle digest_valid rises
    run_block(1, 1'b0, 1'b1);
    @(negedge CLK);
    chk_bit("same_cycle_ack_ready", bus.blk_ready, 1'b1);
    chk_bit("same_cycle_ack_dv", bus.digest_valid, 1'b0);
`ifdef SHA256_CTRL_BLKCNT_EN
    chk_int("blk_cnt_2", int'(blk_cnt), 2);
`endif
    @(posedge CLK);
    #1;

    // Abort mid-ROUND at t=30
    bus.blk_valid = 1'b1;
    bus.blk_first = 1'b1;
    repeat (32) begin
      @(posedge CLK);
      #1;
    end
    chk_int("pre_abort_t", int'(t), 30);
    chk_bit("pre_abort_rnd", rnd_en, 1'b1);
    RST = 1'b1;
    #1;
    chk_obs("abort_immediate", sample(), rst_exp);
    @(posedge CLK);
    #1;
    chk_obs("abort_held", sample(), rst_exp);
`ifdef SHA256_CTRL_BLKCNT_EN
    chk_int("blk_cnt_reset", int'(blk_cnt), 0);
`endif
    RST = 1'b0;
    bus.blk_valid = 1'b0;
    @(posedge CLK);
    #1;

    run_block(2, 1'b1, 1'b1);
    chk_int("hash_upd_total", n_upd, 3);

`ifdef SHA256_CTRL_BLKCNT_EN
    chk_int("blk_cnt_after_abort", int'(blk_cnt), 1);
    force dut.blk_cnt_q = 16'hFFFF;
    #1;
    release dut.blk_cnt_q;
    @(posedge CLK);
    #1;
    run_block(3, 1'b1, 1'b1);
    chk_int("blk_cnt_sat", int'(blk_cnt), 16'hFFFF);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].blk == 1) begin
        chk_obs($sformatf("%s_blk1_c%0d", vecs[i].name, vecs[i].cyc),
                cap[0][vecs[i].cyc], vecs[i].exp);
        chk_obs($sformatf("%s_postrst_c%0d", vecs[i].name, vecs[i].cyc),
                cap[2][vecs[i].cyc], vecs[i].exp);
      end else begin
        chk_obs($sformatf("%s_c%0d", vecs[i].name, vecs[i].cyc),
                cap[1][vecs[i].cyc], vecs[i].exp);
      end
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
